// File: rtl/rf_alu_dm.sv
// ============================================================================
//  Module      : rf_alu_dm
//  Description : Single-cycle datapath slice: 32x32 register file, 32-bit
//                ALU with funct decode, 64-word data memory and write-back
//                mux. The only output is the ALU zero flag.
//  Option      : define RF_ALU_DM_ZERO_REG_EN to make register 0 read as
//                zero and discard writes to it. Left undefined, register 0
//                is an ordinary writable register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_alu_dm (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [4:0]  Read1,
   input  logic [4:0]  Read2,
   input  logic [4:0]  ins_15_11,
   input  logic [15:0] SEin,
   input  logic        RegDst,
   input  logic        RegWrite,
   input  logic        ALUSrc,
   input  logic        MemtoReg,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [1:0]  ALUOp,
   output logic        Zero
);

   localparam int NUM_REGS  = 32;
   localparam int NUM_WORDS = 64;

   // ALU operation classes
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   // R-type funct codes
   localparam logic [5:0] FUNCT_ADD = 6'd32;
   localparam logic [5:0] FUNCT_SUB = 6'd34;
   localparam logic [5:0] FUNCT_AND = 6'd36;
   localparam logic [5:0] FUNCT_OR  = 6'd37;
   localparam logic [5:0] FUNCT_SLT = 6'd42;

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   logic [31:0] reg_file [NUM_REGS];
   logic [31:0] data_mem [NUM_WORDS];

   // ------------------------------------------------------------------------
   // Datapath nets
   // ------------------------------------------------------------------------
   logic [31:0] rd1;
   logic [31:0] rd2;
   logic [31:0] sign_ext;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic [5:0]  funct;
   logic [5:0]  mem_addr;
   logic [31:0] mem_rdata;
   logic [31:0] wb_data;
   logic [4:0]  wr_addr;
   logic        reg_we;

   // Register file read ports; register 0 is hard-wired when the option is on
   always_comb begin
`ifdef RF_ALU_DM_ZERO_REG_EN
      rd1 = (Read1 == 5'd0) ? 32'd0 : reg_file[Read1];
      rd2 = (Read2 == 5'd0) ? 32'd0 : reg_file[Read2];
`else
      rd1 = reg_file[Read1];
      rd2 = reg_file[Read2];
`endif
   end

   // Destination register select and write enable
   always_comb begin
      wr_addr = RegDst ? ins_15_11 : Read2;
`ifdef RF_ALU_DM_ZERO_REG_EN
      reg_we  = RegWrite && (wr_addr != 5'd0);
`else
      reg_we  = RegWrite;
`endif
   end

   // Immediate sign extension and ALU operand B select
   always_comb begin
      sign_ext = {{16{SEin[15]}}, SEin};
      alu_b    = ALUSrc ? sign_ext : rd2;
      funct    = SEin[5:0];
   end

   // ALU: fixed operation classes plus funct decode; unknown funct gives 0
   always_comb begin
      alu_result = 32'd0;
      case (ALUOp)
         ALUOP_ADD: alu_result = rd1 + alu_b;
         ALUOP_SUB: alu_result = rd1 - alu_b;
         ALUOP_OR:  alu_result = rd1 | alu_b;
         ALUOP_FUNCT: begin
            case (funct)
               FUNCT_ADD: alu_result = rd1 + alu_b;
               FUNCT_SUB: alu_result = rd1 - alu_b;
               FUNCT_AND: alu_result = rd1 & alu_b;
               FUNCT_OR:  alu_result = rd1 | alu_b;
               FUNCT_SLT: alu_result = {31'd0, ($signed(rd1) < $signed(alu_b))};
               default:   alu_result = 32'd0;
            endcase
         end
         default: alu_result = 32'd0;
      endcase
   end

   // Zero flag follows the ALU result directly
   always_comb begin
      Zero = (alu_result == 32'd0);
   end

   // Word address from ALU result; byte offset dropped, upper bits wrap
   always_comb begin
      mem_addr  = alu_result[7:2];
      mem_rdata = MemRead ? data_mem[mem_addr] : 32'd0;
      wb_data   = MemtoReg ? mem_rdata : alu_result;
   end

   // Register file write; reset loads each register with its own index
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            reg_file[i] <= 32'(i);
         end
      end else if (reg_we) begin
         reg_file[wr_addr] <= wb_data;
      end
   end

   // Data memory write; reset loads each word with its own index
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int j = 0; j < NUM_WORDS; j++) begin
            data_mem[j] <= 32'(j);
         end
      end else if (MemWrite) begin
         data_mem[mem_addr] <= rd2;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rf_alu_dm.sv
// ============================================================================
//  Module      : tb_rf_alu_dm
//  Description : Directed self-checking bench for rf_alu_dm. All state is
//                observed through the Zero flag. Honours the optional
//                RF_ALU_DM_ZERO_REG_EN macro for the register-0 check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_alu_dm;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [4:0]  Read1 = '0;
   logic [4:0]  Read2 = '0;
   logic [4:0]  ins_15_11 = '0;
   logic [15:0] SEin = '0;
   logic        RegDst = 1'b0;
   logic        RegWrite = 1'b0;
   logic        ALUSrc = 1'b0;
   logic        MemtoReg = 1'b0;
   logic        MemWrite = 1'b0;
   logic        MemRead = 1'b0;
   logic [1:0]  ALUOp = '0;
   logic        Zero;

   int n_checks = 0;
   int n_pass   = 0;

   rf_alu_dm dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .Read1     (Read1),
      .Read2     (Read2),
      .ins_15_11 (ins_15_11),
      .SEin      (SEin),
      .RegDst    (RegDst),
      .RegWrite  (RegWrite),
      .ALUSrc    (ALUSrc),
      .MemtoReg  (MemtoReg),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ALUOp     (ALUOp),
      .Zero      (Zero)
   );

   always #5 Clock = ~Clock;

   // Let combinational logic settle, then compare Zero
   task automatic check(input string tag, input logic expected);
      #1;
      n_checks++;
      assert (Zero === expected) n_pass++;
      else $error("FAIL %s: observed Zero=%b expected Zero=%b", tag, Zero, expected);
   endtask

   // One rising edge, returning shortly after it
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic clear_ctrl();
      RegDst = 0; RegWrite = 0; ALUSrc = 0; MemtoReg = 0;
      MemWrite = 0; MemRead = 0; ALUOp = 2'b00; SEin = '0;
      Read1 = '0; Read2 = '0; ins_15_11 = '0;
   endtask

   task automatic do_reset();
      Reset = 1;
      tick();
      Reset = 0;
   endtask

   logic exp_r0_zero;

   initial begin
      clear_ctrl();
      do_reset();

      // Reset contents: r0=0, r1=1
      Read1 = 0; Read2 = 0; ALUOp = 2'b00;
      check("reset_r0_plus_r0", 1'b1);
      Read1 = 1;
      check("reset_r1_plus_r0", 1'b0);

      // funct sub: 1-2 = FFFFFFFF, then 2-2 = 0
      Read1 = 1; Read2 = 2; ALUOp = 2'b10; SEin = 16'd34;
      check("funct_sub_nonzero", 1'b0);
      Read1 = 2; Read2 = 2;
      check("funct_sub_zero", 1'b1);

      // Fixed subtract and OR classes
      ALUOp = 2'b01; Read1 = 3; Read2 = 3; SEin = 16'd0;
      check("aluop_sub_equal", 1'b1);
      ALUOp = 2'b11; Read1 = 0; Read2 = 0;
      check("aluop_or_zero", 1'b1);
      Read2 = 1;
      check("aluop_or_nonzero", 1'b0);

      // funct add 1+2=3; undefined funct codes force result 0
      ALUOp = 2'b10; SEin = 16'd32; Read1 = 1; Read2 = 2;
      check("funct_add", 1'b0);
      SEin = 16'd33;
      check("funct_undef_33", 1'b1);
      SEin = 16'd0;
      check("funct_undef_0", 1'b1);

      // Sign extension: r4 + (-4) = 0, r4 + (-5) = -1
      ALUOp = 2'b00; ALUSrc = 1; Read1 = 4; SEin = 16'hFFFC;
      check("signext_add_zero", 1'b1);
      SEin = 16'hFFFB;
      check("signext_add_neg", 1'b0);

      // slt / and / or funct decode
      ALUSrc = 0; ALUOp = 2'b10; SEin = 16'd42; Read1 = 3; Read2 = 4;
      check("slt_3_lt_4", 1'b0);
      Read1 = 4; Read2 = 3;
      check("slt_4_lt_3", 1'b1);
      SEin = 16'd36; Read1 = 1; Read2 = 2;
      check("and_1_2", 1'b1);
      SEin = 16'd37;
      check("or_1_2", 1'b0);

      // r10 <= 0 + (-1) via RegDst=1
      clear_ctrl();
      ALUSrc = 1; SEin = 16'hFFFF; Read1 = 0; RegDst = 1; ins_15_11 = 5'd10; RegWrite = 1;
      tick();
      clear_ctrl();
      ALUSrc = 1; SEin = 16'hFFFF; ALUOp = 2'b01; Read1 = 10;
      check("r10_is_minus1", 1'b1);

      // Signed compare: -1 < 1 true, 1 < -1 false
      ALUSrc = 0; ALUOp = 2'b10; SEin = 16'd42; Read1 = 10; Read2 = 1;
      check("slt_signed_neg_lt_pos", 1'b0);
      Read1 = 1; Read2 = 10;
      check("slt_signed_pos_lt_neg", 1'b1);

      // Store r5 at address 0x14 (word 5), then load word 5 into r7
      clear_ctrl();
      do_reset();
      Read1 = 0; Read2 = 5; ALUSrc = 1; SEin = 16'h0014; ALUOp = 2'b00; MemWrite = 1;
      tick();
      MemWrite = 0; MemRead = 1; MemtoReg = 1; RegWrite = 1; RegDst = 0; Read2 = 7;
      tick();
      clear_ctrl();
      Read1 = 7; Read2 = 5; ALUSrc = 0; ALUOp = 2'b01;
      check("load_r7_eq_r5", 1'b1);

      // Make r10 = -1, store at word 6, reload via wrapped/misaligned addr 0x11B into r11
      clear_ctrl();
      ALUSrc = 1; SEin = 16'hFFFF; Read1 = 0; RegDst = 1; ins_15_11 = 5'd10; RegWrite = 1;
      tick();
      clear_ctrl();
      Read1 = 0; Read2 = 10; ALUSrc = 1; SEin = 16'h0018; MemWrite = 1;
      tick();
      clear_ctrl();
      Read1 = 0; ALUSrc = 1; SEin = 16'h011B; MemRead = 1; MemtoReg = 1;
      RegWrite = 1; RegDst = 1; ins_15_11 = 5'd11;
      tick();
      clear_ctrl();
      Read1 = 11; ALUSrc = 1; SEin = 16'hFFFF; ALUOp = 2'b01;
      check("load_wrap_r11_minus1", 1'b1);
      ALUOp = 2'b00; SEin = 16'd0;
      check("r11_nonzero", 1'b0);

      // MemRead=0 with MemtoReg=1 writes back zero into r12
      clear_ctrl();
      Read1 = 0; ALUSrc = 1; SEin = 16'h0018; MemRead = 0; MemtoReg = 1;
      RegWrite = 1; RegDst = 1; ins_15_11 = 5'd12;
      tick();
      clear_ctrl();
      Read1 = 12; ALUSrc = 1; SEin = 16'd0; ALUOp = 2'b00;
      check("memread_off_gives_zero", 1'b1);

      // Reset beats RegWrite on the same edge: r3 must be 3
      clear_ctrl();
      ALUSrc = 1; SEin = 16'h0077; Read1 = 0; RegDst = 1; ins_15_11 = 5'd3; RegWrite = 1;
      Reset = 1;
      tick();
      Reset = 0;
      clear_ctrl();
      Read1 = 3; ALUSrc = 1; SEin = 16'hFFFD; ALUOp = 2'b00;
      check("reset_priority_r3", 1'b1);

      // Reset beats MemWrite: word 5 must hold 5 after a reset with store of r9
      clear_ctrl();
      Read1 = 0; Read2 = 9; ALUSrc = 1; SEin = 16'h0014; MemWrite = 1;
      Reset = 1;
      tick();
      Reset = 0;
      clear_ctrl();
      Read1 = 0; ALUSrc = 1; SEin = 16'h0014; MemRead = 1; MemtoReg = 1;
      RegWrite = 1; RegDst = 1; ins_15_11 = 5'd13;
      tick();
      clear_ctrl();
      Read1 = 13; ALUSrc = 1; SEin = 16'hFFFB; ALUOp = 2'b00;
      check("reset_priority_mem5", 1'b1);

      // Write 0x14 to r0, then r0 + (-20)
      clear_ctrl();
      ALUSrc = 1; SEin = 16'h0014; Read1 = 0; RegDst = 1; ins_15_11 = 5'd0; RegWrite = 1;
      tick();
      clear_ctrl();
      Read1 = 0; ALUSrc = 1; SEin = 16'hFFEC; ALUOp = 2'b00;
`ifdef RF_ALU_DM_ZERO_REG_EN
      exp_r0_zero = 1'b0;
`else
      exp_r0_zero = 1'b1;
`endif
      check("r0_write", exp_r0_zero);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
